// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: fetches microwords into the MIR, drives datapath controls, and
// computes the next MPC from JAMN/JAMZ/JMPC. Define SINGLE_STEP_EN to gate LOAD on a step input.
module mic1_microsequencer #(
  parameter logic [8:0] HALT_ADDR  = 9'h1FF,
  parameter logic [8:0] START_ADDR = 9'h000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [8:0]  cs_addr,
  input  logic [35:0] cs_data,
  input  logic [31:0] alu_out,
  input  logic [7:0]  mbr,
  input  logic        mem_ready,
  output logic        f0,
  output logic        f1,
  output logic        ena,
  output logic        enb,
  output logic        inva,
  output logic        inc,
  output logic        sll8,
  output logic        sra1,
  output logic [8:0]  c_wr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_fetch,
  output logic [3:0]  bsel,
  output logic        n_flag,
  output logic        z_flag,
  output logic        halted,
  output logic [8:0]  mpc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t      state, state_nx;
  logic [35:0] mir, mir_nx;
  logic [8:0]  mpc_nx, pending_mpc, pending_nx;
  logic        n_nx, z_nx, halted_nx;
  logic        load_go;

  logic [8:0]  mir_next_addr;
  logic        mir_jmpc, mir_jamn, mir_jamz;
  logic        mir_write, mir_read, mir_fetch;
  logic        mem_req;
  logic        n_new, z_new;
  logic [8:0]  jump_addr;

  assign mir_next_addr = mir[35:27];
  assign mir_jmpc      = mir[26];
  assign mir_jamn      = mir[25];
  assign mir_jamz      = mir[24];
  assign mir_write     = mir[6];
  assign mir_read      = mir[5];
  assign mir_fetch     = mir[4];
  assign mem_req       = mir_write | mir_read | mir_fetch;

  assign cs_addr = mpc;

`ifdef SINGLE_STEP_EN
  assign load_go = step;
`else
  assign load_go = 1'b1;
`endif

  // Flags feeding the jump are this cycle's, not the latched ones.
  assign n_new = alu_out[31];
  assign z_new = (alu_out == '0);

  always_comb begin
    jump_addr = mir_next_addr;
    if ((mir_jamn && n_new) || (mir_jamz && z_new))
      jump_addr[8] = 1'b1;
    if (mir_jmpc)
      jump_addr[7:0] = mir_next_addr[7:0] | mbr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      mpc         <= '0;
      mir         <= '0;
      n_flag      <= 1'b0;
      z_flag      <= 1'b0;
      halted      <= 1'b0;
      pending_mpc <= '0;
    end else begin
      state       <= state_nx;
      mpc         <= mpc_nx;
      mir         <= mir_nx;
      n_flag      <= n_nx;
      z_flag      <= z_nx;
      halted      <= halted_nx;
      pending_mpc <= pending_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    mpc_nx     = mpc;
    mir_nx     = mir;
    n_nx       = n_flag;
    z_nx       = z_flag;
    halted_nx  = halted;
    pending_nx = pending_mpc;

    f0        = 1'b0;
    f1        = 1'b0;
    ena       = 1'b0;
    enb       = 1'b0;
    inva      = 1'b0;
    inc       = 1'b0;
    sll8      = 1'b0;
    sra1      = 1'b0;
    c_wr      = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_fetch = 1'b0;
    bsel      = '0;

    unique case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          mpc_nx    = START_ADDR;
          halted_nx = 1'b0;
          state_nx  = S_LOAD;
        end
      end

      S_LOAD: begin
        if (load_go) begin
          mir_nx   = cs_data;
          state_nx = S_EXEC;
        end
      end

      S_EXEC: begin
        sll8      = mir[23];
        sra1      = mir[22];
        f0        = mir[21];
        f1        = mir[20];
        ena       = mir[19];
        enb       = mir[18];
        inva      = mir[17];
        inc       = mir[16];
        c_wr      = mir[15:7];
        mem_wr    = mir_write;
        mem_rd    = mir_read;
        mem_fetch = mir_fetch;
        bsel      = mir[3:0];

        n_nx = n_new;
        z_nx = z_new;

        if (mem_req && !mem_ready) begin
          pending_nx = jump_addr;
          state_nx   = S_WAIT;
        end else if (jump_addr == HALT_ADDR) begin
          mpc_nx    = jump_addr;
          halted_nx = 1'b1;
          state_nx  = S_HALTED;
        end else begin
          mpc_nx   = jump_addr;
          state_nx = S_LOAD;
        end
      end

      S_WAIT: begin
        mem_wr    = mir_write;
        mem_rd    = mir_read;
        mem_fetch = mir_fetch;
        if (mem_ready) begin
          mpc_nx = pending_mpc;
          if (pending_mpc == HALT_ADDR) begin
            halted_nx = 1'b1;
            state_nx  = S_HALTED;
          end else begin
            state_nx = S_LOAD;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Self-checking bench for mic1_microsequencer: directed microwords plus a random
// microprogram checked against a field-level next-address model.
module tb_mic1_microsequencer;

  localparam logic [8:0] HALT  = 9'h1FF;
  localparam logic [8:0] START = 9'h000;

  typedef struct packed {
    logic [8:0] nxt;
    logic       jmpc, jamn, jamz, sll8, sra1, f0, f1, ena, enb, inva, inc;
    logic [8:0] cwr;
    logic       wr, rd, fe;
    logic [3:0] b;
  } mw_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  cs_addr;
  logic [35:0] cs_data;
  logic [31:0] alu_out = '0;
  logic [7:0]  mbr = '0;
  logic        mem_ready = 1'b0;
  logic        f0, f1, ena, enb, inva, inc, sll8, sra1;
  logic [8:0]  c_wr;
  logic        mem_rd, mem_wr, mem_fetch;
  logic [3:0]  bsel;
  logic        n_flag, z_flag, halted;
  logic [8:0]  mpc;
`ifdef SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  logic [35:0] rom [512];
  logic [23:0] ctrl;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_mpc = '0;
  logic       exp_n = 1'b0, exp_z = 1'b0, exp_halted = 1'b0;

  always #5 clk = ~clk;

  assign cs_data = rom[cs_addr];
  assign ctrl = {f0, f1, ena, enb, inva, inc, sll8, sra1, c_wr, mem_rd, mem_wr, mem_fetch, bsel};

  mic1_microsequencer #(.HALT_ADDR(HALT), .START_ADDR(START)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .cs_addr(cs_addr), .cs_data(cs_data), .alu_out(alu_out), .mbr(mbr),
    .mem_ready(mem_ready), .f0(f0), .f1(f1), .ena(ena), .enb(enb), .inva(inva),
    .inc(inc), .sll8(sll8), .sra1(sra1), .c_wr(c_wr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_fetch(mem_fetch), .bsel(bsel), .n_flag(n_flag),
    .z_flag(z_flag), .halted(halted), .mpc(mpc)
  );

  function automatic logic [23:0] exec_ctrl(input mw_t w);
    return {w.f0, w.f1, w.ena, w.enb, w.inva, w.inc, w.sll8, w.sra1, w.cwr, w.rd, w.wr, w.fe, w.b};
  endfunction

  function automatic mw_t halt_word();
    mw_t h = '0;
    h.nxt = HALT;
    return h;
  endfunction

  // Entered at posedge+1 with the DUT in IDLE or HALTED; leaves it in LOAD.
  task automatic start_prog();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_mpc = START;
    exp_halted = 1'b0;
    #1;
    checks++;
    if (mpc !== exp_mpc || halted !== 1'b0) begin
      errors++;
      $display("FAIL start_prog mpc=%h halted=%b required mpc=%h halted=0", mpc, halted, exp_mpc);
    end
  endtask

  // Runs one microword from LOAD: LOAD, EXEC, optional WAIT cycles, then checks the exit.
  task automatic do_word(input int stall, input logic [31:0] alu, input logic [7:0] m);
    mw_t w;
    logic [8:0] nx;
    logic n_new, z_new, req;
    w = mw_t'(rom[exp_mpc]);
    req = w.rd | w.wr | w.fe;
    start = 1'(($urandom & 1));
    mem_ready = 1'(($urandom & 1));
    #3;
    checks++;
    if (cs_addr !== exp_mpc || ctrl !== 24'h0) begin
      errors++;
      $display("FAIL load_phase cs_addr=%h ctrl=%h required cs_addr=%h ctrl=0", cs_addr, ctrl, exp_mpc);
    end
    @(posedge clk); #1;
    alu_out = alu;
    mbr = m;
    mem_ready = req ? (stall == 0) : 1'(($urandom & 1));
    start = 1'(($urandom & 1));
    #3;
    checks++;
    if (ctrl !== exec_ctrl(w)) begin
      errors++;
      $display("FAIL exec_ctrl got %h required %h", ctrl, exec_ctrl(w));
    end
    n_new = alu[31];
    z_new = (alu == 32'd0);
    nx = w.nxt;
    if ((w.jamn && n_new) || (w.jamz && z_new)) nx = nx + ((nx >= 9'h100) ? 9'h0 : 9'h100);
    if (w.jmpc) nx = {nx[8], w.nxt[7:0] | m};
    @(posedge clk); #1;
    if (req && stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        mem_ready = (i == stall - 1);
        start = 1'(($urandom & 1));
        alu_out = $urandom;
        mbr = 8'($urandom);
        #3;
        checks++;
        if (ctrl !== {17'h0, w.rd, w.wr, w.fe, 4'h0} || n_flag !== n_new || z_flag !== z_new ||
            mpc !== exp_mpc || halted !== 1'b0) begin
          errors++;
          $display("FAIL wait_cycle ctrl=%h n=%b z=%b mpc=%h halted=%b required ctrl=%h n=%b z=%b mpc=%h halted=0",
                   ctrl, n_flag, z_flag, mpc, halted, {17'h0, w.rd, w.wr, w.fe, 4'h0}, n_new, z_new, exp_mpc);
        end
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    exp_mpc = nx;
    exp_n = n_new;
    exp_z = z_new;
    exp_halted = (nx == HALT);
    #1;
    checks++;
    if (mpc !== exp_mpc || n_flag !== exp_n || z_flag !== exp_z || halted !== exp_halted) begin
      errors++;
      $display("FAIL word_exit mpc=%h n=%b z=%b halted=%b required mpc=%h n=%b z=%b halted=%b",
               mpc, n_flag, z_flag, halted, exp_mpc, exp_n, exp_z, exp_halted);
    end
    if (exp_halted) begin
      checks++;
      if (ctrl !== 24'h0) begin
        errors++;
        $display("FAIL halted_ctrl got %h required 0", ctrl);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (ctrl !== 24'h0 || cs_addr !== 9'h0 || mpc !== 9'h0 || n_flag !== 1'b0 ||
        z_flag !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_values ctrl=%h cs_addr=%h mpc=%h n=%b z=%b halted=%b required all 0",
               ctrl, cs_addr, mpc, n_flag, z_flag, halted);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mpc !== 9'h0 || ctrl !== 24'h0) begin
      errors++;
      $display("FAIL idle_no_start mpc=%h ctrl=%h required 0 0", mpc, ctrl);
    end
    exp_mpc = '0; exp_n = 1'b0; exp_z = 1'b0; exp_halted = 1'b0;
  endtask

  task automatic test_basic();
    mw_t w = '0;
    w.nxt = 9'h005; w.f0 = 1'b1; w.f1 = 1'b1; w.enb = 1'b1; w.cwr = 9'h100;
    rom[0] = w;
    rom[5] = halt_word();
    start_prog();
    do_word(0, 32'd5, 8'h00);
    do_word(0, 32'd7, 8'h00);
    @(posedge clk); #1;
    checks++;
    if (halted !== 1'b1 || mpc !== HALT || ctrl !== 24'h0) begin
      errors++;
      $display("FAIL halt_hold halted=%b mpc=%h ctrl=%h required 1 %h 0", halted, mpc, ctrl, HALT);
    end
  endtask

  task automatic test_jamz();
    mw_t w = '0;
    w.nxt = 9'h012; w.jamz = 1'b1;
    rom[0] = w;
    rom[9'h112] = halt_word();
    rom[9'h012] = halt_word();
    start_prog();
    do_word(0, 32'd0, 8'h00);
    checks++;
    if (mpc !== 9'h112 || z_flag !== 1'b1) begin
      errors++;
      $display("FAIL jamz_taken mpc=%h z=%b required 112 1", mpc, z_flag);
    end
    do_word(0, 32'd3, 8'h00);
    start_prog();
    do_word(0, 32'd1, 8'h00);
    checks++;
    if (mpc !== 9'h012 || z_flag !== 1'b0) begin
      errors++;
      $display("FAIL jamz_not_taken mpc=%h z=%b required 012 0", mpc, z_flag);
    end
    do_word(0, 32'd0, 8'h00);
  endtask

  task automatic test_jamn();
    mw_t w = '0;
    w.nxt = 9'h020; w.jamn = 1'b1;
    rom[0] = w;
    rom[9'h120] = halt_word();
    start_prog();
    do_word(0, 32'h8000_0000, 8'h00);
    checks++;
    if (mpc !== 9'h120 || n_flag !== 1'b1) begin
      errors++;
      $display("FAIL jamn_taken mpc=%h n=%b required 120 1", mpc, n_flag);
    end
    do_word(0, 32'd9, 8'h00);
  endtask

  task automatic test_jmpc();
    mw_t w = '0;
    w.nxt = 9'h100; w.jmpc = 1'b1;
    rom[0] = w;
    rom[9'h13C] = halt_word();
    start_prog();
    do_word(0, 32'd1, 8'h3C);
    checks++;
    if (mpc !== 9'h13C) begin
      errors++;
      $display("FAIL jmpc_or mpc=%h required 13c", mpc);
    end
    do_word(0, 32'd1, 8'h00);
  endtask

  task automatic test_wait();
    mw_t w = '0;
    w.nxt = 9'h007; w.rd = 1'b1; w.f0 = 1'b1; w.cwr = 9'h1FF; w.b = 4'h3;
    rom[0] = w;
    rom[7] = halt_word();
    start_prog();
    do_word(4, 32'h1234, 8'h00);
    do_word(0, 32'd2, 8'h00);
  endtask

  task automatic test_reset_mid();
    mw_t w = '0;
    w.nxt = 9'h033; w.f1 = 1'b1; w.wr = 1'b1; w.cwr = 9'h044; w.b = 4'hA;
    rom[0] = w;
    start_prog();
    mem_ready = 1'b0;
    @(posedge clk); #1;
    alu_out = 32'h8000_0000;
    #2;
    checks++;
    if (ctrl !== exec_ctrl(w)) begin
      errors++;
      $display("FAIL pre_reset_exec got %h required %h", ctrl, exec_ctrl(w));
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 24'h0 || cs_addr !== 9'h0 || mpc !== 9'h0 || halted !== 1'b0 ||
        n_flag !== 1'b0 || z_flag !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset ctrl=%h cs_addr=%h mpc=%h halted=%b n=%b z=%b required all 0",
               ctrl, cs_addr, mpc, halted, n_flag, z_flag);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_mpc = '0; exp_n = 1'b0; exp_z = 1'b0; exp_halted = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 512; i++) rom[i] = {4'($urandom), $urandom};
    rom[HALT] = halt_word();
    start_prog();
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = 32'h8000_0000 | $urandom;
        default: a = $urandom;
      endcase
      do_word(int'($urandom_range(0, 3)), a, 8'($urandom));
      if (exp_halted) start_prog();
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_jamz();
    test_jamn();
    test_jmpc();
    test_wait();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
